// File: rtl/wb_regfile_writer.sv
// wb_regfile_writer: MEM->WB write buffer, register file strobe sequencer
// and in-flight write scoreboard. Optional bypass macro: WB_BYPASS_EN.
module wb_regfile_writer #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_rd,
    input  logic        mem_regwrite,
    input  logic        mem_memtoreg,
    input  logic [31:0] mem_alu,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  rf_writeregister,
    output logic [31:0] rf_data,
    output logic        rf_regwrite,
    input  logic        dec_issue,
    input  logic [4:0]  dec_rd,
    input  logic        dec_regwrite,
    input  logic [4:0]  dec_rs,
    input  logic [4:0]  dec_rt,
    output logic        hazard_stall,
    output logic        fwd_rs_hit,
    output logic        fwd_rt_hit,
    output logic [31:0] fwd_data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CMAX = '1;

    typedef enum logic [1:0] {IDLE, SETUP, PULSE} state_t;
    state_t state, state_nxt;

    logic [4:0]       fifo_rd   [DEPTH];
    logic [31:0]      fifo_data [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [AW:0]      count;
    logic [CNT_W-1:0] pend [32];

    logic        pop, push;
    logic        sb_inc, sb_dec;
    logic [31:0] inc_vec, dec_vec;
    logic [31:0] mem_sel;

    assign mem_sel     = mem_memtoreg ? mem_rdata : mem_alu;
    assign mem_ready   = (count < FULL) || pop;
    assign push        = mem_valid && mem_ready && mem_regwrite && (mem_rd != 5'd0);
    assign rf_regwrite = (state == PULSE);
    assign fwd_data    = rf_data;
    assign sb_inc      = dec_issue && dec_regwrite && (dec_rd != 5'd0) && !hazard_stall;
    assign sb_dec      = (state == SETUP);

    // Write sequencer: pop into SETUP, then one PULSE cycle per write
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: state_nxt = PULSE;
            PULSE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = SETUP;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Write buffer storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_rd[wr_ptr]   <= mem_rd;
                fifo_data[wr_ptr] <= mem_sel;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Register file address/data, loaded on pop and held otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_writeregister <= 5'd0;
            rf_data          <= 32'd0;
        end else if (pop) begin
            rf_writeregister <= fifo_rd[rd_ptr];
            rf_data          <= fifo_data[rd_ptr];
        end
    end

    // One-hot increment/decrement requests for the scoreboard
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (sb_inc) inc_vec[dec_rd] = 1'b1;
        if (sb_dec) dec_vec[rf_writeregister] = 1'b1;
    end

    // Per-register pending counters; saturate high, clamp at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) pend[r] <= '0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (inc_vec[r] && !dec_vec[r] && pend[r] != CMAX)
                    pend[r] <= pend[r] + 1'b1;
                else if (dec_vec[r] && !inc_vec[r] && pend[r] != '0)
                    pend[r] <= pend[r] - 1'b1;
            end
        end
    end

    // Retiring a write nobody announced means decode and MEM disagree
    always_ff @(posedge clk) begin
        if (!reset && sb_dec && !inc_vec[rf_writeregister])
            assert (pend[rf_writeregister] != '0);
    end

`ifdef WB_BYPASS_EN
    logic in_fifo_rs, in_fifo_rt;
`endif

    // Decode hazard detection with optional bypass of the active write
    always_comb begin
        fwd_rs_hit = 1'b0;
        fwd_rt_hit = 1'b0;
`ifdef WB_BYPASS_EN
        in_fifo_rs = 1'b0;
        in_fifo_rt = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((AW+1)'(i) < count) begin
                if (fifo_rd[rd_ptr + AW'(i)] == dec_rs) in_fifo_rs = 1'b1;
                if (fifo_rd[rd_ptr + AW'(i)] == dec_rt) in_fifo_rt = 1'b1;
            end
        end
        if (state != IDLE) begin
            fwd_rs_hit = (dec_rs == rf_writeregister) && (dec_rs != 5'd0)
                && (pend[dec_rs] == CNT_W'(1)) && !in_fifo_rs;
            fwd_rt_hit = (dec_rt == rf_writeregister) && (dec_rt != 5'd0)
                && (pend[dec_rt] == CNT_W'(1)) && !in_fifo_rt;
        end
`endif
        hazard_stall = ((pend[dec_rs] != '0) && !fwd_rs_hit)
            || ((pend[dec_rt] != '0) && !fwd_rt_hit)
            || (pend[dec_rd] == CMAX);
    end

endmodule
